// File: rtl/zhaoling_pkg.sv
// zhaoling_pkg: denominations, FSM state encoding and one-hot coin select for the change dispenser.
// The GAP state exists only when ZHAOLING_GAP_EN is defined.
package zhaoling_pkg;
   localparam logic [7:0] DEN50 = 8'd50;
   localparam logic [7:0] DEN10 = 8'd10;
   localparam logic [7:0] DEN5  = 8'd5;
   localparam logic [7:0] DEN1  = 8'd1;
`ifdef ZHAOLING_GAP_EN
   typedef enum logic [1:0] {IDLE, PAY, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, PAY} state_t;
`endif
   typedef struct packed {
      logic c50;
      logic c10;
      logic c5;
      logic c1;
   } coin_t;
endpackage

// File: rtl/zhaoling_coin_sel.sv
// zhaoling_coin_sel: greedy pick of the largest coin not exceeding rem, and the remainder after paying it.
module zhaoling_coin_sel
   import zhaoling_pkg::*;
(
   input  logic [7:0] rem_i,
   output coin_t      sel_o,
   output logic [7:0] rem_nxt_o
);
   assign sel_o = rem_i >= DEN50 ? coin_t'(4'b1000) :
                  rem_i >= DEN10 ? coin_t'(4'b0100) :
                  rem_i >= DEN5  ? coin_t'(4'b0010) :
                  rem_i >= DEN1  ? coin_t'(4'b0001) : coin_t'(4'b0000);
   // subtrahend is zero whenever no coin fits, so rem never underflows
   assign rem_nxt_o = rem_i - (sel_o.c50 ? DEN50 : sel_o.c10 ? DEN10 :
                               sel_o.c5 ? DEN5 : sel_o.c1 ? DEN1 : 8'd0);
endmodule

// File: rtl/zhaoling.sv
// zhaoling: change-dispense controller paying out a loaded amount as 50/10/5/1 single-cycle pulses.
// Define ZHAOLING_GAP_EN to insert a low GAP cycle after every pulse.
module zhaoling
   import zhaoling_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       shift,
   input  logic [7:0] money,
   output logic       qian1,
   output logic       qian5,
   output logic       qian10,
   output logic       qian50
);
   state_t     state_q, state_d;
   logic [7:0] rem_q, rem_d, rem_nxt;
   coin_t      coin_q, coin_d, sel;

   zhaoling_coin_sel u_sel (
      .rem_i     (rem_q),
      .sel_o     (sel),
      .rem_nxt_o (rem_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         coin_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         coin_q  <= coin_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      coin_d  = '0;
      case (state_q)
         IDLE: if (shift) begin
            rem_d   = money;
            state_d = PAY;
         end
         PAY: if (rem_q == '0) state_d = IDLE;
         else begin
            coin_d = sel;
            rem_d  = rem_nxt;
`ifdef ZHAOLING_GAP_EN
            state_d = GAP;
`endif
         end
`ifdef ZHAOLING_GAP_EN
         GAP: state_d = PAY;
`endif
         default: state_d = IDLE;
      endcase
   end

   assign qian50 = coin_q.c50;
   assign qian10 = coin_q.c10;
   assign qian5  = coin_q.c5;
   assign qian1  = coin_q.c1;
endmodule

// File: tb/tb_zhaoling.sv
// tb_zhaoling: directed scoreboard bench; every cycle's expected {qian50,qian10,qian5,qian1} is queued at load time.
// Honours ZHAOLING_GAP_EN to model the inserted gap cycles.
module tb_zhaoling;
   logic       clk = 1'b0;
   logic       rst, shift;
   logic [7:0] money;
   logic       qian1, qian5, qian10, qian50;
   logic [3:0] q[$];
   int tests = 0, fails = 0, paid = 0, n50 = 0, p0, n0, nq;

   zhaoling dut (
      .clk    (clk),
      .rst    (rst),
      .shift  (shift),
      .money  (money),
      .qian1  (qian1),
      .qian5  (qian5),
      .qian10 (qian10),
      .qian50 (qian50)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one cycle: sample on the falling edge, compare against the scoreboard, then release for driving
   task automatic tick();
      logic [3:0] obs, exp;
      @(negedge clk);
      obs = {qian50, qian10, qian5, qian1};
      exp = q.size() > 0 ? q.pop_front() : 4'b0000;
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL cycle_out observed=%b expected=%b", obs, exp);
      end
      chk("onehot", int'($countones(obs) <= 1), 1);
      paid += (obs[3] ? 50 : 0) + (obs[2] ? 10 : 0) + (obs[1] ? 5 : 0) + (obs[0] ? 1 : 0);
      n50  += obs[3] ? 1 : 0;
      #1;
   endtask

   task automatic push_load(input int m);
      int r = m;
      int d;
      q.push_back(4'b0000);
      while (r > 0) begin
         d = r >= 50 ? 50 : r >= 10 ? 10 : r >= 5 ? 5 : 1;
         q.push_back(d == 50 ? 4'b1000 : d == 10 ? 4'b0100 : d == 5 ? 4'b0010 : 4'b0001);
`ifdef ZHAOLING_GAP_EN
         q.push_back(4'b0000);
`endif
         r -= d;
      end
      q.push_back(4'b0000);
   endtask

   task automatic load(input int m);
      shift = 1'b1;
      money = 8'(m);
      push_load(m);
      tick();
      shift = 1'b0;
      money = 8'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && q.size() > 0; i++) tick();
      chk("drain_timeout", q.size(), 0);
   endtask

   task automatic run(input int m);
      p0 = paid;
      load(m);
      drain();
      tick();
      tick();
      chk("sum_paid", paid - p0, m);
   endtask

   initial begin
      rst   = 1'b0;
      shift = 1'b1;
      money = 8'd77;
      tick();
      tick();
      chk("reset_outputs", {qian50, qian10, qian5, qian1}, 0);
      rst   = 1'b1;
      shift = 1'b0;
      tick();
      run(117);
      run(255);
      run(4);
      run(0);
      // second request during PAY must be ignored
      p0 = paid;
      load(117);
      tick();
      tick();
      shift = 1'b1;
      money = 8'd9;
      tick();
      shift = 1'b0;
      drain();
      repeat (3) tick();
      chk("ignore_sum", paid - p0, 117);
      // shift held high reloads each time IDLE is re-entered
      p0 = paid;
      shift = 1'b1;
      money = 8'd6;
      push_load(6);
      nq = q.size();
      push_load(6);
      for (int i = 0; i < 100 && q.size() >= nq; i++) tick();
      chk("held_reload_seen", int'(q.size() < nq), 1);
      shift = 1'b0;
      money = 8'd0;
      drain();
      repeat (3) tick();
      chk("held_sum", paid - p0, 12);
      // reset after the second 50 pulse discards the remainder
      p0 = paid;
      n0 = n50;
      load(117);
      for (int i = 0; i < 50 && n50 - n0 < 2; i++) tick();
      chk("two_50_seen", n50 - n0, 2);
      rst = 1'b0;
      q.delete();
      tick();
      chk("reset_mid_out", {qian50, qian10, qian5, qian1}, 0);
      rst = 1'b1;
      repeat (6) tick();
      chk("reset_mid_sum", paid - p0, 100);
      run(4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
